// File: rtl/edge_event_arbiter_if.sv
// rtl/edge_event_arbiter_if.sv - level-input / event-handshake bundle for edge_event_arbiter
interface edge_event_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   level;
    logic           ready;
    logic           clr_overrun;
    logic           valid;
    logic [IDW-1:0] chan;
    logic [N-1:0]   pending;
    logic [N-1:0]   overrun;

    // Driver of levels and consumer of events
    modport master (
        output level, ready, clr_overrun,
        input  valid, chan, pending, overrun
    );

    // The arbiter itself
    modport slave (
        input  level, ready, clr_overrun,
        output valid, chan, pending, overrun
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel rising-edge capture with round-robin event serialiser
module edge_event_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic               clk,
    input  logic               reset,
    edge_event_arbiter_if.slave bus
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_prev;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   r_overrun;
    logic [IDW-1:0] r_chan;
    logic [IDW-1:0] r_ptr;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_clear;
    logic [N-1:0]   w_pending_next;
    logic [N-1:0]   w_overrun_next;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    logic           w_accept;
    logic           w_grant;

    // Mealy edge: current level against the level seen last clock
    assign w_edge   = bus.level & ~r_prev;
    assign w_accept = (r_state == S_OFFER) && bus.ready;

    // One-hot of the channel whose event is being consumed this clock
    always_comb begin
        w_clear = '0;
        if (w_accept) begin
            w_clear[r_chan] = 1'b1;
        end
    end

    // A fresh edge beats the consume; an edge onto a still-held event is an overrun
    assign w_pending_next = (r_pending & ~w_clear) | w_edge;
    assign w_overrun_next = (bus.clr_overrun ? {N{1'b0}} : r_overrun)
                          | (w_edge & r_pending & ~w_clear);

    // Round-robin search upward from ptr+1 with an explicit wrap at N-1
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_idx = (w_idx == IDW'(N - 1)) ? '0 : w_idx + IDW'(1);
            if (!w_found && r_pending[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Arbiter next state: offer when anything is held, release on ready
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_OFFER;
                    w_grant      = 1'b1;
                end
            end
            S_OFFER: begin
                if (bus.ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Arbiter state, offered index and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_ptr   <= IDW'(N - 1);
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_chan <= w_sel;
            end
            if (w_accept) begin
                r_ptr <= r_chan;
            end
        end
    end

    // Per-channel history, held-event and overrun flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_prev    <= bus.level;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign bus.valid   = (r_state == S_OFFER);
    assign bus.chan    = r_chan;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed and randomized bench for edge_event_arbiter
module tb_edge_event_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    edge_event_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference: events held per channel, one offer slot, last-served channel
    bit         m_valid;
    int         m_chan;
    int         m_ptr;
    bit [N-1:0] m_pend;
    bit [N-1:0] m_ov;
    bit [N-1:0] m_prev;

    int grants[$];
    int grant_cyc[$];

    task automatic model_reset();
        m_valid = 1'b0;
        m_chan  = 0;
        m_ptr   = N - 1;
        m_pend  = '0;
        m_ov    = '0;
        m_prev  = '0;
    endtask

    task automatic model_clock();
        bit         accept;
        bit [N-1:0] old_pend;
        bit         e;
        bit         cl;
        if (!reset) begin
            model_reset();
            return;
        end
        accept   = m_valid && bus.ready;
        old_pend = m_pend;
        for (int i = 0; i < N; i++) begin
            e  = bus.level[i] && !m_prev[i];
            cl = accept && (m_chan == i);
            if (e && old_pend[i] && !cl) m_ov[i] = 1'b1;
            else if (bus.clr_overrun)   m_ov[i] = 1'b0;
            if (e)       m_pend[i] = 1'b1;
            else if (cl) m_pend[i] = 1'b0;
        end
        m_prev = bus.level;
        if (!m_valid) begin
            for (int k = 1; k <= N; k++) begin
                if (old_pend[(m_ptr + k) % N]) begin
                    m_chan  = (m_ptr + k) % N;
                    m_valid = 1'b1;
                    break;
                end
            end
        end else if (bus.ready) begin
            m_ptr   = m_chan;
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        if (reset && bus.valid && bus.ready) begin
            grants.push_back(int'(bus.chan));
            grant_cyc.push_back(cycle);
        end
        @(posedge clk);
        model_clock();
        cycle++;
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.level       = '0;
        bus.ready       = 1'b0;
        bus.clr_overrun = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b1;
        grants.delete();
        grant_cyc.delete();
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.level       = 4'hF;
        bus.ready       = 1'b1;
        bus.clr_overrun = 1'b0;
        model_reset();
        repeat (3) step();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.valid); end
        checks++; if (bus.chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", bus.chan); end
        checks++; if (bus.pending !== 4'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0000", bus.pending); end
        checks++; if (bus.overrun !== 4'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0000", bus.overrun); end
    endtask

    task automatic test_single_event();
        int extra_valid;
        do_reset();
        bus.ready = 1'b1;
        repeat (5) begin
            step();
            checks++;
            if (bus.valid !== m_valid || bus.pending !== m_pend) begin
                errors++; $display("FAIL single_idle: dut v=%0b p=%b exp v=%0b p=%b", bus.valid, bus.pending, m_valid, m_pend);
            end
        end
        bus.level = 4'b0100;
        step();
        checks++; if (bus.pending !== 4'b0100 || bus.valid !== 1'b0) begin errors++; $display("FAIL single_pending: got p=%b v=%0b expected p=0100 v=0", bus.pending, bus.valid); end
        step();
        checks++; if (bus.valid !== 1'b1 || bus.chan !== 2'd2) begin errors++; $display("FAIL single_offer: got v=%0b c=%0d expected v=1 c=2", bus.valid, bus.chan); end
        step();
        checks++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0) begin errors++; $display("FAIL single_accept: got v=%0b p=%b expected v=0 p=0000", bus.valid, bus.pending); end
        extra_valid = 0;
        repeat (6) begin
            step();
            if (bus.valid !== 1'b0) extra_valid++;
        end
        checks++; if (extra_valid != 0) begin errors++; $display("FAIL single_hold: got %0d extra valid cycles expected 0", extra_valid); end
        checks++; if (grants.size() != 1 || grants[0] != 2) begin errors++; $display("FAIL single_grants: got %0d grants expected 1 for chan 2", grants.size()); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.ready = 1'b1;
        bus.level = 4'hF;
        repeat (10) begin
            step();
            checks++;
            if (bus.valid !== m_valid || (m_valid && bus.chan !== IDW'(m_chan)) || bus.pending !== m_pend) begin
                errors++; $display("FAIL rr_model: cyc %0d dut v=%0b c=%0d p=%b exp v=%0b c=%0d p=%b", cycle, bus.valid, bus.chan, bus.pending, m_valid, m_chan, m_pend);
            end
        end
        checks++;
        if (grants.size() != 4) begin
            errors++; $display("FAIL rr_count: got %0d grants expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != i) begin errors++; $display("FAIL rr_order: grant %0d got chan %0d expected %0d", i, grants[i], i); end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (grant_cyc[i] - grant_cyc[i-1] != 2) begin errors++; $display("FAIL rr_spacing: got %0d cycles expected 2", grant_cyc[i] - grant_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_back_pressure();
        int stable_bad;
        for (int variant = 0; variant < 2; variant++) begin
            do_reset();
            bus.level = 4'b0010;
            step();
            step();
            checks++; if (bus.valid !== 1'b1 || bus.chan !== 2'd1) begin errors++; $display("FAIL bp_offer: got v=%0b c=%0d expected v=1 c=1", bus.valid, bus.chan); end
            bus.level = (variant == 0) ? 4'b0011 : 4'b0111;
            stable_bad = 0;
            repeat (5) begin
                step();
                if (bus.valid !== 1'b1 || bus.chan !== 2'd1) stable_bad++;
            end
            checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", stable_bad); end
            bus.ready = 1'b1;
            repeat (4) step();
            checks++;
            if (grants.size() < 2 || grants[0] != 1 || grants[1] != ((variant == 0) ? 0 : 2)) begin
                errors++; $display("FAIL bp_next: variant %0d got %0d grants next=%0d expected next %0d", variant, grants.size(),
                                   (grants.size() > 1) ? grants[1] : -1, (variant == 0) ? 0 : 2);
            end
        end
    endtask

    task automatic test_overrun();
        int ch1_grants;
        do_reset();
        bus.level = 4'b0001;
        step();
        step();
        bus.level = 4'b0011;
        step();
        bus.level = 4'b0001;
        step();
        bus.level = 4'b0011;
        step();
        checks++; if (bus.overrun !== 4'b0010 || bus.pending[1] !== 1'b1) begin errors++; $display("FAIL ovr_set: got o=%b p=%b expected o=0010 p[1]=1", bus.overrun, bus.pending); end
        bus.ready = 1'b1;
        repeat (8) step();
        ch1_grants = 0;
        foreach (grants[i]) if (grants[i] == 1) ch1_grants++;
        checks++; if (ch1_grants != 1) begin errors++; $display("FAIL ovr_single_event: got %0d chan1 events expected 1", ch1_grants); end
        checks++; if (grants.size() < 1 || grants[0] != 0) begin errors++; $display("FAIL ovr_first: got %0d grants expected first chan 0", grants.size()); end
        checks++; if (bus.overrun !== 4'b0010) begin errors++; $display("FAIL ovr_sticky: got %b expected 0010", bus.overrun); end
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b expected 0000", bus.overrun); end
        bus.ready = 1'b0;
        bus.level = 4'b0001;
        step();
        bus.level = 4'b0011;
        step();
        bus.level = 4'b0001;
        step();
        bus.level       = 4'b0011;
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        checks++; if (bus.overrun !== 4'b0010) begin errors++; $display("FAIL ovr_clear_collide: got %b expected 0010", bus.overrun); end
    endtask

    task automatic test_edge_on_accept();
        do_reset();
        bus.level = 4'b0100;
        step();
        step();
        checks++; if (bus.valid !== 1'b1 || bus.chan !== 2'd2) begin errors++; $display("FAIL eoa_offer: got v=%0b c=%0d expected v=1 c=2", bus.valid, bus.chan); end
        bus.level = 4'b0000;
        step();
        bus.level = 4'b0100;
        bus.ready = 1'b1;
        step();
        checks++; if (bus.pending[2] !== 1'b1 || bus.overrun[2] !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL eoa_flags: got p=%b o=%b v=%0b expected p[2]=1 o[2]=0 v=0", bus.pending, bus.overrun, bus.valid); end
        step();
        checks++; if (bus.valid !== 1'b1 || bus.chan !== 2'd2) begin errors++; $display("FAIL eoa_regrant: got v=%0b c=%0d expected v=1 c=2", bus.valid, bus.chan); end
        step();
        checks++; if (grants.size() != 2 || grants[0] != 2 || grants[1] != 2) begin errors++; $display("FAIL eoa_grants: got %0d grants expected two for chan 2", grants.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.level = 4'b1000;
        step();
        step();
        bus.level = 4'b0000;
        step();
        bus.level = 4'b1000;
        step();
        checks++; if (bus.valid !== 1'b1 || bus.overrun !== 4'b1000) begin errors++; $display("FAIL rmid_pre: got v=%0b o=%b expected v=1 o=1000", bus.valid, bus.overrun); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0 || bus.overrun !== 4'b0) begin errors++; $display("FAIL rmid_async: got v=%0b p=%b o=%b expected all 0", bus.valid, bus.pending, bus.overrun); end
        model_reset();
        bus.level = 4'b0001;
        step();
        reset = 1'b1;
        grants.delete();
        step();
        checks++; if (bus.pending !== 4'b0001 || bus.valid !== 1'b0) begin errors++; $display("FAIL rmid_first_edge: got p=%b v=%0b expected p=0001 v=0", bus.pending, bus.valid); end
        step();
        checks++; if (bus.valid !== 1'b1 || bus.chan !== 2'd0) begin errors++; $display("FAIL rmid_offer: got v=%0b c=%0d expected v=1 c=0", bus.valid, bus.chan); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.level       = 4'($urandom);
            bus.ready       = ($urandom_range(0, 3) != 0);
            bus.clr_overrun = ($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (bus.valid !== m_valid || (m_valid && bus.chan !== IDW'(m_chan)) || bus.pending !== m_pend || bus.overrun !== m_ov) begin
                errors++;
                $display("FAIL rand_model: cyc %0d dut v=%0b c=%0d p=%b o=%b exp v=%0b c=%0d p=%b o=%b",
                         cycle, bus.valid, bus.chan, bus.pending, bus.overrun, m_valid, m_chan, m_pend, m_ov);
            end
        end
        bus.level       = '0;
        bus.ready       = 1'b0;
        bus.clr_overrun = 1'b0;
    endtask

    initial begin
        bus.level       = '0;
        bus.ready       = 1'b0;
        bus.clr_overrun = 1'b0;
        model_reset();
        test_reset();
        test_single_event();
        test_round_robin();
        test_back_pressure();
        test_overrun();
        test_edge_on_accept();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
